uart_bus_arbiter: RTL and testbench

UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

---
 rtl/uart_bus_arbiter.sv | 70 +++++++
 tb/tb_uart_bus_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin arbiter that shares one UART register bus between two requesters
module uart_bus_arbiter #(
   parameter int unsigned ACCESS_CYCLES  = 2,
   parameter int unsigned RECOVER_CYCLES = 1
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [1:0] req_i,
   input  logic [1:0] we_i,
   input  logic [2:0] addr0_i,
   input  logic [2:0] addr1_i,
   input  logic [7:0] wdata0_i,
   input  logic [7:0] wdata1_i,
   output logic [1:0] gnt_o,
   output logic [1:0] done_o,
   output logic [7:0] rdata_o,
   output logic       chip_sel_n_o,
   output logic       read_write_o,
   output logic [2:0] address_o,
   output logic [7:0] data_o,
   input  logic [7:0] data_i
);
   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
   state_t     state_q, state_d;
   logic [3:0] cnt_q;
   logic       last_q, owner_q, accept, sel, last_cyc;

   assign sel = gnt_o[1];

   always_comb begin
      gnt_o        = (rst_n_i && state_q == IDLE) ? ((req_i == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_i) : 2'b00;
      chip_sel_n_o = state_q != ACCESS;
   end

   always_comb begin
      accept   = |(req_i & gnt_o);
      last_cyc = cnt_q == 4'd1;
      state_d  = (state_q == IDLE) ? (accept ? ACCESS : IDLE) :
                 last_cyc ? ((state_q == ACCESS) ? RECOVER : IDLE) : state_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         last_q       <= 1'b1;
         owner_q      <= 1'b0;
         done_o       <= 2'b00;
         rdata_o      <= 8'h00;
         read_write_o <= 1'b1;
         address_o    <= 3'd0;
         data_o       <= 8'h00;
      end else begin
         state_q <= state_d;
         // counter reloads on every state change and counts down while busy
         cnt_q   <= (state_d != state_q) ?
                    ((state_d == ACCESS) ? 4'(ACCESS_CYCLES) : (state_d == RECOVER) ? 4'(RECOVER_CYCLES) : 4'd0) :
                    ((state_q == IDLE) ? cnt_q : cnt_q - 4'd1);
         done_o  <= (state_q == ACCESS && last_cyc) ? {owner_q, ~owner_q} : 2'b00;
         if (state_q == ACCESS && last_cyc) rdata_o <= read_write_o ? data_i : 8'h00;
         if (accept) begin
            owner_q      <= sel;
            last_q       <= sel;
            address_o    <= sel ? addr1_i : addr0_i;
            read_write_o <= ~we_i[sel];
            data_o       <= sel ? wdata1_i : wdata0_i;
         end
      end
   end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: default and 5/3 timing instances checked against a transaction-timeline model
module tb_uart_bus_arbiter;
   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic [1:0] req_i = 2'b00, we_i = 2'b00;
   logic [2:0] addr0_i = 3'd0, addr1_i = 3'd0;
   logic [7:0] wdata0_i = 8'h00, wdata1_i = 8'h00, data_i = 8'h00;
   logic [1:0] gnt [2];
   logic [1:0] done [2];
   logic [7:0] rdata [2];
   logic [7:0] dout [2];
   logic [2:0] addr [2];
   logic       cs [2];
   logic       rw [2];

   int   errors = 0, checks = 0, cyc = 0;
   bit   armed = 0;
   int   ac [2] = '{2, 5};
   int   rc [2] = '{1, 3};
   int   acc_cyc [2] = '{-1, -1};
   logic owner_m [2], last_m [2], rw_m [2];
   logic [2:0] addr_m [2];
   logic [7:0] data_m [2], rdata_m [2];

   always #5 clk_i = ~clk_i;

   uart_bus_arbiter u0 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i),
      .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .gnt_o(gnt[0]), .done_o(done[0]), .rdata_o(rdata[0]), .chip_sel_n_o(cs[0]),
      .read_write_o(rw[0]), .address_o(addr[0]), .data_o(dout[0]), .data_i(data_i)
   );

   uart_bus_arbiter #(.ACCESS_CYCLES(5), .RECOVER_CYCLES(3)) u1 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i),
      .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .gnt_o(gnt[1]), .done_o(done[1]), .rdata_o(rdata[1]), .chip_sel_n_o(cs[1]),
      .read_write_o(rw[1]), .address_o(addr[1]), .data_o(dout[1]), .data_i(data_i)
   );

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
      end
   endtask

   function automatic logic [1:0] arb(input logic [1:0] rq, input logic last);
      return (rq == 2'b11) ? (last ? 2'b01 : 2'b10) : rq;
   endfunction

   // an access accepted in cycle t owns the bus until cycle t+ACCESS+RECOVER+1
   task automatic model(input int i);
      bit busy;
      int k;
      logic [1:0] g;
      busy = acc_cyc[i] >= 0 && (cyc - acc_cyc[i]) < ac[i] + rc[i] + 1;
      k    = busy ? cyc - acc_cyc[i] : 0;
      g    = (!rst_n_i || busy) ? 2'b00 : arb(req_i, last_m[i]);
      chk("gnt", i, 32'(gnt[i]), 32'(g));
      if (armed) begin
         chk("cs_n", i, 32'(cs[i]), (busy && k >= 1 && k <= ac[i]) ? 32'd0 : 32'd1);
         chk("done", i, 32'(done[i]), (busy && k == ac[i] + 1) ? (owner_m[i] ? 32'd2 : 32'd1) : 32'd0);
         chk("rdata", i, 32'(rdata[i]), 32'(rdata_m[i]));
         chk("address", i, 32'(addr[i]), 32'(addr_m[i]));
         chk("read_write", i, 32'(rw[i]), 32'(rw_m[i]));
         chk("data", i, 32'(dout[i]), 32'(data_m[i]));
      end
      if (!rst_n_i) begin
         acc_cyc[i] = -1; last_m[i] = 1'b1; owner_m[i] = 1'b0; rw_m[i] = 1'b1;
         addr_m[i] = 3'd0; data_m[i] = 8'h00; rdata_m[i] = 8'h00;
      end else begin
         if (busy && k == ac[i]) rdata_m[i] = rw_m[i] ? data_i : 8'h00;
         if (g != 2'b00) begin
            acc_cyc[i] = cyc;
            owner_m[i] = g[1];
            last_m[i]  = g[1];
            addr_m[i]  = g[1] ? addr1_i : addr0_i;
            rw_m[i]    = ~we_i[g[1]];
            data_m[i]  = g[1] ? wdata1_i : wdata0_i;
         end
      end
   endtask

   task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] wv, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] di);
      @(negedge clk_i);
      rst_n_i = r; req_i = rq; we_i = wv; addr0_i = a0; addr1_i = a1;
      wdata0_i = w0; wdata1_i = w1; data_i = di;
      #1;
      for (int i = 0; i < 2; i++) model(i);
      if (!r) armed = 1;
      cyc++;
   endtask

   task automatic rnd_step(input logic r, input logic [1:0] rq);
      step(r, rq, 2'($urandom()), 3'($urandom()), 3'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom()));
   endtask

   initial begin
      rnd_step(1'b0, 2'b11);
      rnd_step(1'b0, 2'b00);
      step(1'b1, 2'b01, 2'b00, 3'd5, 3'd0, 8'h11, 8'h22, 8'h3C);
      for (int n = 0; n < 10; n++) step(1'b1, 2'b00, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00, 8'h3C);
      step(1'b1, 2'b10, 2'b10, 3'd0, 3'd3, 8'h00, 8'hA5, 8'h77);
      for (int n = 0; n < 10; n++) rnd_step(1'b1, 2'b00);
      for (int n = 0; n < 24; n++) rnd_step(1'b1, 2'b11);
      for (int n = 0; n < 10; n++) rnd_step(1'b1, 2'b00);
      for (int n = 0; n < 24; n++) rnd_step(1'b1, 2'b10);
      for (int n = 0; n < 10; n++) rnd_step(1'b1, 2'b00);
      rnd_step(1'b1, 2'b01);
      rnd_step(1'b1, 2'b00);
      rnd_step(1'b0, 2'b00);
      rnd_step(1'b1, 2'b11);
      for (int n = 0; n < 10; n++) rnd_step(1'b1, 2'b00);
      for (int n = 0; n < 400; n++) rnd_step(1'($urandom_range(0, 40) != 0), 2'($urandom()));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
